// File: rtl/parking_system.sv
// Car-park entry gate controller: sensors, 2+2-bit password,
// green/red lamps and a two-digit 7-segment status readout.
module parking_system #(
  parameter logic [1:0] PASS_1      = 2'b01,
  parameter logic [1:0] PASS_2      = 2'b10,
  parameter logic [2:0] WAIT_CYCLES = 3'd4
) (
  input  logic       clock_in,
  input  logic       rst_in,
  input  logic       Front_Sensor,
  input  logic       Back_Sensor,
  input  logic [1:0] pass_1,
  input  logic [1:0] pass_2,
  output logic       G_LED,
  output logic       R_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_P     = 7'h0C;

  state_t     state;
  state_t     next_state;
  logic [2:0] wait_cnt;
  logic [2:0] wait_nxt;
  logic       blink;
  logic       pw_ok;

  assign pw_ok = (pass_1 == PASS_1) && (pass_2 == PASS_2);

  // State, wait counter and blink phase registers.
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      blink    <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_nxt;
      blink    <= ~blink;
    end
  end

  // Next-state logic; the counter only runs while staying in WAIT_PASSWORD.
  always_comb begin
    next_state = IDLE;
    wait_nxt   = 3'd0;
    unique case (state)
      IDLE: begin
        next_state = Front_Sensor ? WAIT_PASSWORD : IDLE;
      end
      WAIT_PASSWORD: begin
        if (wait_cnt < WAIT_CYCLES) begin
          next_state = WAIT_PASSWORD;
          wait_nxt   = wait_cnt + 3'd1;
        end else begin
          next_state = pw_ok ? RIGHT_PASS : WRONG_PASS;
        end
      end
      WRONG_PASS: begin
        next_state = pw_ok ? RIGHT_PASS : WRONG_PASS;
      end
      RIGHT_PASS: begin
        if (Front_Sensor && Back_Sensor)
          next_state = STOP;
        else if (Back_Sensor)
          next_state = IDLE;
        else
          next_state = RIGHT_PASS;
      end
      STOP: begin
        next_state = pw_ok ? RIGHT_PASS : STOP;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Lamp and display decode from registered state and blink.
  always_comb begin
    G_LED = 1'b0;
    R_LED = 1'b0;
    HEX_1 = SEG_BLANK;
    HEX_2 = SEG_BLANK;
    unique case (state)
      WAIT_PASSWORD: begin
        R_LED = 1'b1;
        HEX_1 = SEG_E;
        HEX_2 = SEG_N;
      end
      WRONG_PASS: begin
        R_LED = blink;
        HEX_1 = SEG_E;
        HEX_2 = SEG_E;
      end
      RIGHT_PASS: begin
        G_LED = blink;
        HEX_1 = SEG_6;
        HEX_2 = SEG_0;
      end
      STOP: begin
        R_LED = blink;
        HEX_1 = SEG_5;
        HEX_2 = SEG_P;
      end
      default: begin
        G_LED = 1'b0;
        R_LED = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_parking_system.sv
// Directed vector bench for parking_system, plus a
// short-wait instance exercising WAIT_CYCLES=1.
module tb_parking_system;

  logic       clk;
  logic       rst;
  logic       front;
  logic       back;
  logic [1:0] p1;
  logic [1:0] p2;

  logic       g0, r0, g1, r1;
  logic [6:0] h1_0, h2_0, h1_1, h2_1;

  int checks;
  int failures;
  logic blink_m;

  localparam int S_IDLE  = 0;
  localparam int S_WAIT  = 1;
  localparam int S_WRONG = 2;
  localparam int S_RIGHT = 3;
  localparam int S_STOP  = 4;

  // lamp codes: 0 off, 1 on, 2 follows blink
  typedef struct {
    logic       rst;
    logic       front;
    logic       back;
    logic [1:0] p1;
    logic [1:0] p2;
    int         g_code;
    int         r_code;
    logic [6:0] hex1;
    logic [6:0] hex2;
  } vec_t;

  vec_t vecs[$];

  parking_system dut (
    .clock_in    (clk),
    .rst_in      (rst),
    .Front_Sensor(front),
    .Back_Sensor (back),
    .pass_1      (p1),
    .pass_2      (p2),
    .G_LED       (g0),
    .R_LED       (r0),
    .HEX_1       (h1_0),
    .HEX_2       (h2_0)
  );

  parking_system #(.WAIT_CYCLES(3'd1)) dut_w1 (
    .clock_in    (clk),
    .rst_in      (rst),
    .Front_Sensor(front),
    .Back_Sensor (back),
    .pass_1      (p1),
    .pass_2      (p2),
    .G_LED       (g1),
    .R_LED       (r1),
    .HEX_1       (h1_1),
    .HEX_2       (h2_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rs, input logic f,
                     input logic b, input logic [1:0] a,
                     input logic [1:0] c, input int st);
    vec_t v;
    v.rst = rs; v.front = f; v.back = b;
    v.p1 = a; v.p2 = c;
    case (st)
      S_WAIT:  begin v.g_code = 0; v.r_code = 1;
                     v.hex1 = 7'h06; v.hex2 = 7'h2B; end
      S_WRONG: begin v.g_code = 0; v.r_code = 2;
                     v.hex1 = 7'h06; v.hex2 = 7'h06; end
      S_RIGHT: begin v.g_code = 2; v.r_code = 0;
                     v.hex1 = 7'h02; v.hex2 = 7'h40; end
      S_STOP:  begin v.g_code = 0; v.r_code = 2;
                     v.hex1 = 7'h12; v.hex2 = 7'h0C; end
      default: begin v.g_code = 0; v.r_code = 0;
                     v.hex1 = 7'h7F; v.hex2 = 7'h7F; end
    endcase
    vecs.push_back(v);
  endtask

  function automatic logic lamp(input int code, input logic bl);
    return (code == 2) ? bl : (code == 1);
  endfunction

  task automatic drive(input logic rs, input logic f,
                       input logic b, input logic [1:0] a,
                       input logic [1:0] c);
    @(negedge clk);
    rst = rs; front = f; back = b; p1 = a; p2 = c;
    @(posedge clk);
    blink_m = rs ? 1'b0 : ~blink_m;
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; blink_m = 1'b0;
    rst = 1'b1; front = 1'b0; back = 1'b0; p1 = 2'b00; p2 = 2'b00;

    // reset, then wrong password path
    add(1, 0, 0, 2'b00, 2'b00, S_IDLE);
    add(1, 0, 0, 2'b00, 2'b00, S_IDLE);
    add(0, 0, 0, 2'b00, 2'b00, S_IDLE);
    add(0, 1, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 1, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WRONG);
    add(0, 0, 0, 2'b00, 2'b00, S_WRONG);
    add(0, 0, 1, 2'b11, 2'b10, S_WRONG);
    add(0, 0, 0, 2'b01, 2'b10, S_RIGHT);
    add(0, 0, 0, 2'b01, 2'b10, S_RIGHT);
    add(0, 0, 1, 2'b01, 2'b10, S_IDLE);
    // password only counts at the evaluation clock
    add(0, 1, 0, 2'b01, 2'b10, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b01, 2'b10, S_RIGHT);
    // next car arrives as first leaves
    add(0, 1, 1, 2'b00, 2'b00, S_STOP);
    add(0, 0, 0, 2'b00, 2'b00, S_STOP);
    add(0, 0, 0, 2'b01, 2'b10, S_RIGHT);
    add(0, 0, 0, 2'b01, 2'b10, S_RIGHT);
    // reset in RIGHT, then reset mid-wait
    add(1, 0, 0, 2'b01, 2'b10, S_IDLE);
    add(0, 1, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(1, 0, 0, 2'b00, 2'b00, S_IDLE);
    add(0, 1, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WAIT);
    add(0, 0, 0, 2'b00, 2'b00, S_WRONG);
    add(0, 0, 0, 2'b00, 2'b00, S_WRONG);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [15:0] act;
      logic [15:0] exp;
      drive(vecs[i].rst, vecs[i].front, vecs[i].back,
            vecs[i].p1, vecs[i].p2);
      act = {g0, r0, h1_0, h2_0};
      exp = {lamp(vecs[i].g_code, blink_m),
             lamp(vecs[i].r_code, blink_m),
             vecs[i].hex1, vecs[i].hex2};
      check($sformatf("vec%0d", i), act, exp);
    end

    // WAIT_CYCLES=1: evaluation after two clocks in WAIT
    drive(1, 0, 0, 2'b00, 2'b00);
    check("w1_reset", {g1, r1, h1_1, h2_1}, {2'b00, 7'h7F, 7'h7F});
    drive(0, 1, 0, 2'b00, 2'b00);
    check("w1_wait0", {g1, r1, h1_1, h2_1}, {2'b01, 7'h06, 7'h2B});
    drive(0, 0, 0, 2'b00, 2'b00);
    check("w1_wait1", {g1, r1, h1_1, h2_1}, {2'b01, 7'h06, 7'h2B});
    drive(0, 0, 0, 2'b00, 2'b00);
    check("w1_wrong", {1'b0, h1_1, h2_1}, {1'b0, 7'h06, 7'h06});
    check("w1_wrong_r", {15'd0, r1}, {15'd0, blink_m});
    check("w4_still_wait", {g0, r0, h1_0, h2_0},
          {2'b01, 7'h06, 7'h2B});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
